// File: rtl/nn_forward_sequencer.sv
// Instruction sequencer for the NU array: fetches from instruction memory and
// drives MATMUL/ACCMOV phases of FORWARD instructions with a hardware repeat count.
module nn_forward_sequencer #(
    parameter int unsigned NU_COUNT   = 8,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned REP_W      = 4,
    parameter int unsigned INST_DEPTH = 8,
    parameter int unsigned W_DEPTH    = 12,
    parameter int unsigned XY_DEPTH   = 12,
    parameter int unsigned INST_W     = 4 + 2*LEN_W + REP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic [INST_W-1:0]     inst_data,
    output logic [INST_DEPTH-1:0] inst_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [NU_COUNT-1:0]   mac_reg_enable,
    output logic                  mac_acc_loopback,
    output logic [W_DEPTH-1:0]    w_read_addr,
    output logic [XY_DEPTH-1:0]   xy_read_addr,
    output logic [XY_DEPTH-1:0]   xy_write_addr,
    output logic                  xy_write_enable
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP     = 4'd0;
    localparam logic [OP_W-1:0] OP_FORWARD = 4'd1;
    localparam logic [OP_W-1:0] OP_SETPTR  = 4'd2;
    localparam logic [OP_W-1:0] OP_HALT    = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MATMUL,
        S_ACCMOV,
        S_FINISH
    } state_t;

    state_t                state, state_nxt;
    logic [LEN_W-1:0]      counter, counter_nxt;
    logic [REP_W-1:0]      rep_cnt, rep_cnt_nxt;
    logic [LEN_W-1:0]      len0, len0_nxt;
    logic [LEN_W-1:0]      len1, len1_nxt;
    logic [REP_W-1:0]      rep, rep_nxt;
    logic [XY_DEPTH-1:0]   xy_read_base, xy_read_base_nxt;
    logic [INST_DEPTH-1:0] inst_addr_nxt;
    logic                  error_nxt;
    logic [W_DEPTH-1:0]    w_read_addr_nxt;
    logic [XY_DEPTH-1:0]   xy_read_addr_nxt;
    logic [XY_DEPTH-1:0]   xy_write_addr_nxt;

    logic [OP_W-1:0]  dec_op;
    logic [LEN_W-1:0] dec_l0;
    logic [LEN_W-1:0] dec_l1;
    logic [REP_W-1:0] dec_r;

    assign dec_op = inst_data[INST_W-1 -: OP_W];
    assign dec_l0 = inst_data[INST_W-OP_W-1 -: LEN_W];
    assign dec_l1 = inst_data[INST_W-OP_W-LEN_W-1 -: LEN_W];
    assign dec_r  = inst_data[REP_W-1:0];

    // State and datapath registers; stall freezes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            counter       <= '0;
            rep_cnt       <= '0;
            len0          <= '0;
            len1          <= '0;
            rep           <= '0;
            xy_read_base  <= '0;
            inst_addr     <= '0;
            error         <= 1'b0;
            w_read_addr   <= '0;
            xy_read_addr  <= '0;
            xy_write_addr <= '0;
        end else if (!stall) begin
            state         <= state_nxt;
            counter       <= counter_nxt;
            rep_cnt       <= rep_cnt_nxt;
            len0          <= len0_nxt;
            len1          <= len1_nxt;
            rep           <= rep_nxt;
            xy_read_base  <= xy_read_base_nxt;
            inst_addr     <= inst_addr_nxt;
            error         <= error_nxt;
            w_read_addr   <= w_read_addr_nxt;
            xy_read_addr  <= xy_read_addr_nxt;
            xy_write_addr <= xy_write_addr_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt         = state;
        counter_nxt       = counter;
        rep_cnt_nxt       = rep_cnt;
        len0_nxt          = len0;
        len1_nxt          = len1;
        rep_nxt           = rep;
        xy_read_base_nxt  = xy_read_base;
        inst_addr_nxt     = inst_addr;
        error_nxt         = error;
        w_read_addr_nxt   = w_read_addr;
        xy_read_addr_nxt  = xy_read_addr;
        xy_write_addr_nxt = xy_write_addr;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt     = S_FETCH;
                    inst_addr_nxt = '0;
                    error_nxt     = 1'b0;
                end
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (dec_op)
                    OP_NOP: begin
                        inst_addr_nxt = inst_addr + INST_DEPTH'(1);
                        state_nxt     = S_FETCH;
                    end
                    OP_SETPTR: begin
                        w_read_addr_nxt   = W_DEPTH'(dec_l0);
                        xy_read_addr_nxt  = XY_DEPTH'(dec_l1);
                        xy_write_addr_nxt = XY_DEPTH'(dec_l1);
                        inst_addr_nxt     = inst_addr + INST_DEPTH'(1);
                        state_nxt         = S_FETCH;
                    end
                    OP_FORWARD: begin
                        if (32'(dec_l1) >= NU_COUNT) begin
                            error_nxt = 1'b1;
                            state_nxt = S_FINISH;
                        end else begin
                            len0_nxt         = dec_l0;
                            len1_nxt         = dec_l1;
                            rep_nxt          = dec_r;
                            counter_nxt      = '0;
                            rep_cnt_nxt      = '0;
                            xy_read_base_nxt = xy_read_addr;
                            state_nxt        = S_MATMUL;
                        end
                    end
                    OP_HALT: state_nxt = S_FINISH;
                    default: begin
                        error_nxt = 1'b1;
                        state_nxt = S_FINISH;
                    end
                endcase
            end
            S_MATMUL: begin
                w_read_addr_nxt  = w_read_addr + W_DEPTH'(1);
                xy_read_addr_nxt = xy_read_addr + XY_DEPTH'(1);
                if (counter == len0) begin
                    counter_nxt = '0;
                    state_nxt   = S_ACCMOV;
                end else begin
                    counter_nxt = counter + LEN_W'(1);
                end
            end
            S_ACCMOV: begin
                xy_write_addr_nxt = xy_write_addr + XY_DEPTH'(1);
                if (counter == len1) begin
                    counter_nxt = '0;
                    if (rep_cnt < rep) begin
                        rep_cnt_nxt      = rep_cnt + REP_W'(1);
                        xy_read_addr_nxt = xy_read_base;
                        state_nxt        = S_MATMUL;
                    end else begin
                        inst_addr_nxt = inst_addr + INST_DEPTH'(1);
                        state_nxt     = S_FETCH;
                    end
                end else begin
                    counter_nxt = counter + LEN_W'(1);
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobes decoded from state; stall masks the enables and the done pulse
    always_comb begin
        busy             = (state != S_IDLE);
        done             = 1'b0;
        mac_reg_enable   = '0;
        mac_acc_loopback = 1'b0;
        xy_write_enable  = 1'b0;

        case (state)
            S_MATMUL: begin
                mac_acc_loopback = (counter != '0);
                if (!stall) begin
                    mac_reg_enable = '1;
                end
            end
            S_ACCMOV: begin
                if (!stall) begin
                    mac_reg_enable  = NU_COUNT'(1) << counter;
                    xy_write_enable = 1'b1;
                end
            end
            S_FINISH: done = !stall;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nn_forward_sequencer.sv
// Bench for nn_forward_sequencer: a program-level trace model predicts every
// cycle's outputs, and a negedge compare process checks the DUT against it.
module tb_nn_forward_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] inst_data;
    logic [7:0]  inst_addr;
    logic        busy, done, error;
    logic [7:0]  mac_reg_enable;
    logic        mac_acc_loopback;
    logic [11:0] w_read_addr, xy_read_addr, xy_write_addr;
    logic        xy_write_enable;

    nn_forward_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stall            (stall),
        .inst_data        (inst_data),
        .inst_addr        (inst_addr),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mac_reg_enable   (mac_reg_enable),
        .mac_acc_loopback (mac_acc_loopback),
        .w_read_addr      (w_read_addr),
        .xy_read_addr     (xy_read_addr),
        .xy_write_addr    (xy_write_addr),
        .xy_write_enable  (xy_write_enable)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle read latency
    logic [31:0] mem [256];
    always @(posedge clk) inst_data <= mem[inst_addr];

    typedef struct {
        logic        busy;
        logic        done;
        logic        err;
        logic        xwe;
        logic        loop;
        logic [7:0]  mre;
        logic [7:0]  ia;
        logic [11:0] w;
        logic [11:0] xr;
        logic [11:0] xw;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_w = '0, m_xr = '0, m_xw = '0;
    int          trace_len;
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    bit          active = 1'b0;
    int          done_cnt = 0, wr_cnt = 0, mm_cnt = 0;

    function automatic void check_val(input string name, input logic [31:0] act,
                                      input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [11:0] l0,
                                       input logic [11:0] l1, input logic [3:0] r);
        return {op, l0, l1, r};
    endfunction

    function automatic void push(input logic bz, input logic dn, input logic er,
                                 input logic we, input logic lp, input logic [7:0] re,
                                 input logic [7:0] ia);
        exp_t e;
        e.busy = bz; e.done = dn; e.err = er; e.xwe = we; e.loop = lp;
        e.mre = re; e.ia = ia; e.w = m_w; e.xr = m_xr; e.xw = m_xw;
        exp_q.push_back(e);
    endfunction

    // Walk the program and list the expected outputs of every unstalled cycle
    function automatic void gen_model();
        logic [7:0]  pc;
        logic        err;
        logic [31:0] ins;
        logic [3:0]  op, r;
        logic [11:0] l0, l1, base;
        logic [7:0]  one;
        bit          fin;
        int          guard;
        pc = '0; err = 1'b0; fin = 1'b0; guard = 0; one = 8'h01;
        exp_q.delete();
        while (!fin && guard < 300) begin
            guard++;
            ins = mem[pc];
            op = ins[31:28]; l0 = ins[27:16]; l1 = ins[15:4]; r = ins[3:0];
            push(1'b1, 1'b0, err, 1'b0, 1'b0, 8'h00, pc);
            push(1'b1, 1'b0, err, 1'b0, 1'b0, 8'h00, pc);
            case (op)
                4'd0: pc++;
                4'd2: begin m_w = l0; m_xr = l1; m_xw = l1; pc++; end
                4'd1: begin
                    if (l1 >= 12'd8) begin
                        err = 1'b1; fin = 1'b1;
                    end else begin
                        base = m_xr;
                        for (int p = 0; p <= int'(r); p++) begin
                            for (int c = 0; c <= int'(l0); c++) begin
                                push(1'b1, 1'b0, err, 1'b0, c != 0, 8'hFF, pc);
                                m_w++; m_xr++;
                            end
                            for (int c = 0; c <= int'(l1); c++) begin
                                push(1'b1, 1'b0, err, 1'b1, 1'b0, one << c, pc);
                                m_xw++;
                            end
                            if (p < int'(r)) m_xr = base;
                        end
                        pc++;
                    end
                end
                4'd3: fin = 1'b1;
                default: begin err = 1'b1; fin = 1'b1; end
            endcase
        end
        push(1'b1, 1'b1, err, 1'b0, 1'b0, 8'h00, pc);
        push(1'b0, 1'b0, err, 1'b0, 1'b0, 8'h00, pc);
        trace_len = exp_q.size();
    endfunction

    // Compare every cycle of a run against the model; stalled cycles hold the entry
    always @(negedge clk) begin
        exp_t e;
        if (active && !reset && exp_q.size() > 0) begin
            e = exp_q[0];
            check_val("busy", 32'(busy), 32'(e.busy));
            check_val("done", 32'(done), 32'(e.done & ~stall));
            check_val("error", 32'(error), 32'(e.err));
            check_val("inst_addr", 32'(inst_addr), 32'(e.ia));
            check_val("mac_reg_enable", 32'(mac_reg_enable), stall ? 32'h0 : 32'(e.mre));
            check_val("xy_write_enable", 32'(xy_write_enable), 32'(e.xwe & ~stall));
            check_val("mac_acc_loopback", 32'(mac_acc_loopback), 32'(e.loop));
            check_val("w_read_addr", 32'(w_read_addr), 32'(e.w));
            check_val("xy_read_addr", 32'(xy_read_addr), 32'(e.xr));
            check_val("xy_write_addr", 32'(xy_write_addr), 32'(e.xw));
            if (!stall) void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (xy_write_enable) wr_cnt++;
            if (mac_reg_enable == 8'hFF) mm_cnt++;
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'h0);
        check_val({tag, "_done"}, 32'(done), 32'h0);
        check_val({tag, "_error"}, 32'(error), 32'h0);
        check_val({tag, "_inst_addr"}, 32'(inst_addr), 32'h0);
        check_val({tag, "_mre"}, 32'(mac_reg_enable), 32'h0);
        check_val({tag, "_xwe"}, 32'(xy_write_enable), 32'h0);
        check_val({tag, "_loop"}, 32'(mac_acc_loopback), 32'h0);
        check_val({tag, "_w"}, 32'(w_read_addr), 32'h0);
        check_val({tag, "_xr"}, 32'(xy_read_addr), 32'h0);
        check_val({tag, "_xw"}, 32'(xy_write_addr), 32'h0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic run_prog(input int stall_from, input int stall_len,
                            input int busy_start_at, input int abort_at);
        int n;
        gen_model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        active = 1'b1;
        n = 1;
        while (exp_q.size() != 0 && n < 3000) begin
            stall = (n >= stall_from) && (n < stall_from + stall_len);
            start = (n == busy_start_at);
            if (n == abort_at) begin
                #2 reset = 1'b1;
                #1 check_all_zero("abort");
                exp_q.delete();
                active = 1'b0;
                m_w = '0; m_xr = '0; m_xw = '0;
                @(posedge clk); #1 reset = 1'b0;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        check_val("run_complete", 32'(exp_q.size()), 32'h0);
        stall = 1'b0;
        start = 1'b0;
        active = 1'b0;
    endtask

    initial begin
        int d0, w0, m0;
        clear_mem();
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // SETPTR, single-pass FORWARD, HALT
        clear_mem();
        mem[0] = mk(4'd2, 12'h010, 12'h020, 4'd0);
        mem[1] = mk(4'd1, 12'd3, 12'd1, 4'd0);
        mem[2] = mk(4'd3, 12'd0, 12'd0, 4'd0);
        d0 = done_cnt; w0 = wr_cnt; m0 = mm_cnt;
        run_prog(0, 0, 0, 0);
        check_val("A_trace_len", 32'(trace_len), 32'd14);
        check_val("A_w_end", 32'(w_read_addr), 32'h014);
        check_val("A_xr_end", 32'(xy_read_addr), 32'h024);
        check_val("A_xw_end", 32'(xy_write_addr), 32'h022);
        check_val("A_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_val("A_writes", 32'(wr_cnt - w0), 32'd2);
        check_val("A_matmul_cycles", 32'(mm_cnt - m0), 32'd4);

        // Three passes with xy_read_addr rewinding
        clear_mem();
        mem[0] = mk(4'd1, 12'd1, 12'd0, 4'd2);
        mem[1] = mk(4'd3, 12'd0, 12'd0, 4'd0);
        w0 = wr_cnt;
        run_prog(0, 0, 0, 0);
        check_val("B_w_end", 32'(w_read_addr), 32'h01A);
        check_val("B_xr_end", 32'(xy_read_addr), 32'h026);
        check_val("B_xw_end", 32'(xy_write_addr), 32'h025);
        check_val("B_writes", 32'(wr_cnt - w0), 32'd3);

        // L1 out of range
        clear_mem();
        mem[0] = mk(4'd1, 12'd2, 12'd8, 4'd0);
        d0 = done_cnt; m0 = mm_cnt;
        run_prog(0, 0, 0, 0);
        check_val("C_error", 32'(error), 32'h1);
        check_val("C_matmul_cycles", 32'(mm_cnt - m0), 32'd0);
        check_val("C_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Next start clears error
        clear_mem();
        mem[0] = mk(4'd2, 12'h010, 12'h020, 4'd0);
        mem[1] = mk(4'd1, 12'd3, 12'd1, 4'd0);
        mem[2] = mk(4'd3, 12'd0, 12'd0, 4'd0);
        run_prog(0, 0, 0, 0);
        check_val("C_error_cleared", 32'(error), 32'h0);

        // Illegal opcode at address 2
        clear_mem();
        mem[2] = mk(4'hF, 12'd0, 12'd0, 4'd0);
        d0 = done_cnt;
        run_prog(0, 0, 0, 0);
        check_val("D_error", 32'(error), 32'h1);
        check_val("D_inst_addr", 32'(inst_addr), 32'h2);
        check_val("D_busy", 32'(busy), 32'h0);
        check_val("D_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Stall for three cycles on the second ACCMOV cycle
        clear_mem();
        mem[0] = mk(4'd2, 12'h100, 12'h200, 4'd0);
        mem[1] = mk(4'd1, 12'd1, 12'd3, 4'd0);
        mem[2] = mk(4'd3, 12'd0, 12'd0, 4'd0);
        w0 = wr_cnt;
        run_prog(8, 3, 0, 0);
        check_val("E_writes", 32'(wr_cnt - w0), 32'd4);
        check_val("E_xw_end", 32'(xy_write_addr), 32'h204);

        // Start while busy is ignored, then reset aborts mid-MATMUL
        clear_mem();
        mem[0] = mk(4'd2, 12'h030, 12'h040, 4'd0);
        mem[1] = mk(4'd1, 12'd7, 12'd2, 4'd1);
        mem[2] = mk(4'd3, 12'd0, 12'd0, 4'd0);
        d0 = done_cnt;
        run_prog(0, 0, 6, 9);
        repeat (2) @(posedge clk);
        #1;
        check_val("F_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("F_busy_idle", 32'(busy), 32'h0);

        // HALT at address 0 after the abort
        clear_mem();
        mem[0] = mk(4'd3, 12'd0, 12'd0, 4'd0);
        d0 = done_cnt;
        run_prog(0, 0, 0, 0);
        check_val("G_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_val("G_w_end", 32'(w_read_addr), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/nn_forward_sequencer.md
Name: nn_forward_sequencer

Overview:
- Parametrised instruction sequencer for the NU array; the next generation of the FORWARD-only controller.
- Fetches instructions from instruction memory (1-cycle read latency) and runs multi-phase FORWARD instructions (MATMUL, then ACCMOV) with a hardware repeat count.
- Also supports pointer-setting, HALT and stall, with a start/busy/done handshake to the host.
- Sits between instruction memory and the MAC/XY/W datapath.

Parameters:
NU_COUNT, 8, number of neuron units; sets mac_reg_enable width
LEN_W, 12, width of the length and pointer fields
REP_W, 4, width of the repeat field
INST_DEPTH, 8, instruction address width
W_DEPTH, 12, weight memory address width
XY_DEPTH, 12, XY memory address width
INST_W, 4+2*LEN_W+REP_W, instruction width (derived; default 32)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; accepted only in IDLE
stall  in  1  freezes all state and suppresses write/enable strobes while high
inst_data  in  INST_W  instruction read data, valid one cycle after inst_addr
inst_addr  out  INST_DEPTH  instruction fetch address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on HALT completion
error  out  1  sticky; cleared by start or reset
mac_reg_enable  out  NU_COUNT  per-NU enable; one-hot in ACCMOV, all ones in MATMUL
mac_acc_loopback  out  1  0 on first MATMUL cycle of a pass, 1 afterwards
w_read_addr  out  W_DEPTH  weight read pointer
xy_read_addr  out  XY_DEPTH  activation read pointer
xy_write_addr  out  XY_DEPTH  result write pointer
xy_write_enable  out  1  high each non-stalled ACCMOV cycle

Behaviour:
- Instruction fields: op=[INST_W-1 -: 4], L0=next LEN_W bits, L1=next LEN_W bits, R=low REP_W bits.
- Opcodes: 0 NOP, 1 FORWARD, 2 SETPTR, 3 HALT; 4..15 illegal.
- Reset (async): state IDLE; all address outputs 0; busy, done, error, xy_write_enable, mac_acc_loopback all 0; mac_reg_enable 0.
- States: IDLE, FETCH, DECODE, MATMUL, ACCMOV, FINISH.
- IDLE: start goes to FETCH. inst_addr is set to 0 and error is cleared. start is ignored in any other state.
- FETCH: drives inst_addr for one cycle. Next state is DECODE, which samples inst_data.
- DECODE:
  - NOP: inst_addr+1, then FETCH.
  - SETPTR: w_read_addr <= L0, xy_read_addr <= L1 (both zero-extended or truncated to their depth), xy_write_addr <= L1; then inst_addr+1, FETCH.
  - FORWARD: latch L0/L1/R; counter=0, rep_cnt=0; go to MATMUL. If L1 >= NU_COUNT, set error and go to FINISH instead.
  - HALT: go to FINISH.
  - Illegal opcode: set error, go to FINISH.
- MATMUL: lasts L0+1 cycles (counter 0..L0).
  - Each cycle: mac_reg_enable all ones, w_read_addr+1, xy_read_addr+1.
  - mac_acc_loopback = (counter != 0).
  - When counter == L0: counter resets to 0, go to ACCMOV.
- ACCMOV: lasts L1+1 cycles.
  - Each cycle: mac_reg_enable = 1 << counter, xy_write_enable=1, xy_write_addr+1 after the write.
  - When counter == L1:
    - if rep_cnt < R: rep_cnt+1, xy_read_addr rewinds to the value latched at FORWARD decode, go to MATMUL;
    - else: inst_addr+1, go to FETCH.
  - A FORWARD therefore executes R+1 passes.
- FINISH: done=1 for exactly one cycle, then IDLE. inst_addr is held.
- Stall:
  - State, counters and pointers hold.
  - xy_write_enable and mac_reg_enable are forced to 0.
  - A stall in FETCH or DECODE delays decode; inst_data is re-sampled when the stall releases.
- Pointers wrap modulo 2^depth silently. inst_addr wraps from max to 0.
- An asynchronous reset mid-instruction aborts immediately with no done pulse.
- L0=0 gives a 1-cycle MATMUL. L1=0 gives a 1-cycle ACCMOV.

Test Plan:
- Reset, then start with program [SETPTR L0=0x010 L1=0x020; FORWARD L0=3 L1=1 R=0; HALT] -> 4 MATMUL cycles with w_read_addr 0x010..0x013 and loopback 0,1,1,1; 2 ACCMOV cycles with mac_reg_enable 0x01,0x02 and xy_write_addr 0x020,0x021; done pulse exactly once; busy drops the next cycle.
- FORWARD L0=1 L1=0 R=2 -> 3 passes; xy_read_addr rewinds to its latched value each pass; 3 writes at consecutive xy_write_addr; w_read_addr advances by 6.
- FORWARD with L1=NU_COUNT (8) -> error=1, no MATMUL cycles, done pulse; a following start clears error.
- Illegal opcode 0xF at address 2 -> error=1, inst_addr holds 2, done pulse, state IDLE.
- stall held 3 cycles mid-ACCMOV -> xy_write_enable=0 and pointers frozen during the stall; the sequence resumes with no lost or duplicated write.
- Async reset asserted during MATMUL -> all outputs 0 in the same cycle, no done; start pulse while busy is ignored (inst_addr unaffected).
